// File: rtl/text_overlay_pipe_if.sv
// Font ROM bus between the text overlay and its synchronous 2048x8 glyph ROM.
// The ROM returns font_word one clock after it samples rom_addr.
interface text_overlay_pipe_if;
  logic [10:0] rom_addr;
  logic [7:0]  font_word;

  modport master (output rom_addr, input  font_word);
  modport slave  (input  rom_addr, output font_word);
endinterface

// File: rtl/text_overlay_pipe.sv
// Text overlay for the snake display: status line, blinking game-over banner and high score.
// Pixel inputs reach text_on/text_rgb exactly two clocks later; the font ROM read fills the first stage.
module text_overlay_pipe #(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [7:0]  FG_RGB       = 8'hFF,
  parameter logic [7:0]  HI_RGB       = 8'hFC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  video_on,
  input  logic                  frame_tick,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [4*DIGITS-1:0]   score,
  input  logic                  g_over,
  text_overlay_pipe_if.master   rom,
  output logic                  text_on,
  output logic [7:0]            text_rgb,
  output logic [4*DIGITS-1:0]   high
);

  localparam int unsigned W = 4 * DIGITS;

  // Status-line column boundaries (8-pixel cells) and banner column boundaries (32-pixel cells).
  localparam logic [6:0] ST_DIG0  = 7'd6;
  localparam logic [6:0] ST_BLANK = 7'(6 + DIGITS);
  localparam logic [6:0] ST_HI0   = 7'(7 + DIGITS);
  localparam logic [6:0] ST_HID0  = 7'(12 + DIGITS);
  localparam logic [6:0] ST_END   = 7'(12 + 2 * DIGITS);
  localparam logic [4:0] BN_LBL0  = 5'd6;
  localparam logic [4:0] BN_DIG0  = 5'd12;
  localparam logic [4:0] BN_END   = 5'(12 + DIGITS);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  function automatic logic [6:0] score_label(input logic [2:0] i);
    case (i)
      3'd0:    return 7'h53;
      3'd1:    return 7'h63;
      3'd2:    return 7'h6F;
      3'd3:    return 7'h72;
      3'd4:    return 7'h65;
      default: return 7'h3A;
    endcase
  endfunction

  function automatic logic [6:0] high_label(input logic [2:0] i);
    case (i)
      3'd0:    return 7'h48;
      3'd1:    return 7'h69;
      3'd2:    return 7'h67;
      3'd3:    return 7'h68;
      default: return 7'h3A;
    endcase
  endfunction

  // Digit idx counts from the most significant BCD nibble; A-F map straight onto 3A-3F.
  function automatic logic [6:0] digit_char(input logic [W-1:0] val, input logic [6:0] idx);
    logic [3:0] d;
    d = 4'h0;
    for (int i = 0; i < int'(DIGITS); i++)
      if (idx == 7'(i)) d = val[4*(int'(DIGITS)-1-i) +: 4];
    return {3'b011, d};
  endfunction

  logic [W-1:0] high_q, high_d;
  logic         new_high_q, new_high_d;
  logic         g_over_dly_q, g_over_dly_d;
  logic [7:0]   blink_cnt_q, blink_cnt_d;
  logic         visible_q, visible_d;
  logic         s1_on_q, s1_on_d;
  logic         s1_hi_q, s1_hi_d;
  logic [2:0]   s1_bit_q, s1_bit_d;
  logic         text_on_q, text_on_d;
  logic [7:0]   text_rgb_q, text_rgb_d;

  logic [6:0] st_col, st_code, code;
  logic [2:0] st_off_hi;
  logic [4:0] bn_col;
  logic [6:0] bn_code;
  logic       st_region, bn_region, bn_digit, region, g_rise;
  logic [3:0] row;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    st_col    = pix_x[9:3];
    bn_col    = pix_x[9:5];
    st_off_hi = 3'(st_col - ST_HI0);
    st_region = (pix_y[9:4] == 6'd0) && (st_col < ST_END);
    st_code   = 7'h00;
    if (st_col < ST_DIG0)        st_code = score_label(st_col[2:0]);
    else if (st_col < ST_BLANK)  st_code = digit_char(score, st_col - ST_DIG0);
    else if (st_col == ST_BLANK) st_code = 7'h00;
    else if (st_col < ST_HID0)   st_code = high_label(st_off_hi);
    else if (st_col < ST_END)    st_code = digit_char(high_q, st_col - ST_HID0);

    bn_region = (pix_y[9:6] == 4'd3) && (bn_col >= BN_LBL0) && (bn_col < BN_END);
    bn_digit  = (bn_col >= BN_DIG0);
    bn_code   = bn_digit ? digit_char(score, {2'b00, bn_col - BN_DIG0})
                         : score_label(3'(bn_col - BN_LBL0));

    region = g_over ? bn_region : st_region;
    code   = !region ? 7'h00 : (g_over ? bn_code : st_code);
    row    = g_over ? pix_y[5:2] : pix_y[3:0];

    // The status line ignores the blink phase; only the banner hides.
    s1_on_d  = region && video_on && (!g_over || visible_q);
    s1_hi_d  = g_over && bn_digit && new_high_q;
    s1_bit_d = g_over ? pix_x[4:2] : pix_x[2:0];

    text_on_d  = s1_on_q;
    text_rgb_d = (s1_on_q && rom.font_word[3'd7 - s1_bit_q]) ? (s1_hi_q ? HI_RGB : FG_RGB) : 8'h00;

    g_over_dly_d = g_over;
    g_rise       = g_over && !g_over_dly_q;
    high_d       = high_q;
    new_high_d   = new_high_q;
    if (!g_over) begin
      new_high_d = 1'b0;
    end else if (g_rise && (score > high_q)) begin
      high_d     = score;
      new_high_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (!g_over) begin
      blink_cnt_d = 8'd0;
      visible_d   = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        visible_d   = !visible_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  assign rom.rom_addr = {code, row};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop sample pre-edge values, keeping stages aligned.
    if (reset) begin
      high_q       <= '0;
      new_high_q   <= 1'b0;
      g_over_dly_q <= 1'b0;
      blink_cnt_q  <= 8'd0;
      visible_q    <= 1'b1;
      s1_on_q      <= 1'b0;
      s1_hi_q      <= 1'b0;
      s1_bit_q     <= 3'd0;
      text_on_q    <= 1'b0;
      text_rgb_q   <= 8'h00;
    end else begin
      high_q       <= high_d;
      new_high_q   <= new_high_d;
      g_over_dly_q <= g_over_dly_d;
      blink_cnt_q  <= blink_cnt_d;
      visible_q    <= visible_d;
      s1_on_q      <= s1_on_d;
      s1_hi_q      <= s1_hi_d;
      s1_bit_q     <= s1_bit_d;
      text_on_q    <= text_on_d;
      text_rgb_q   <= text_rgb_d;
    end
  end

  assign text_on  = text_on_q;
  assign text_rgb = text_rgb_q;
  assign high     = high_q;

endmodule

// File: tb/tb_text_overlay_pipe.sv
// Directed bench for text_overlay_pipe (DIGITS=2, BLINK_FRAMES=2) with a scrambled-pattern font ROM.
// Pixels are driven on the falling edge; each pixel's output is checked two cycles later.
module tb_text_overlay_pipe;
  localparam logic [7:0] FG = 8'hFF;
  localparam logic [7:0] HI = 8'hFC;

  logic       clk = 1'b0;
  logic       reset = 1'b1, video_on = 1'b0, frame_tick = 1'b0, g_over = 1'b0;
  logic [9:0] pix_x = 10'h3FF, pix_y = 10'h3FF;
  logic [7:0] score = 8'h42;
  logic       text_on;
  logic [7:0] text_rgb, high;

  always #5 clk = ~clk;

  text_overlay_pipe_if rom_if ();

  text_overlay_pipe #(
    .DIGITS(2), .BLINK_FRAMES(2), .FG_RGB(FG), .HI_RGB(HI)
  ) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
    .pix_x(pix_x), .pix_y(pix_y), .score(score), .g_over(g_over),
    .rom(rom_if), .text_on(text_on), .text_rgb(text_rgb), .high(high)
  );

  function automatic logic [7:0] font(input logic [10:0] a);
    return {a[3:0], a[7:4]} ^ a[10:3];
  endfunction

  always @(posedge clk) rom_if.font_word <= font(rom_if.rom_addr);

  int tests = 0;
  int fails = 0;
  logic       g_over_n = 1'b0, tick_n = 1'b0;
  logic [7:0] score_n = 8'h42;
  logic       exp_on_q [$];
  logic [7:0] exp_rgb_q [$];
  string      exp_tag_q [$];
  logic [7:0] st_codes [16] = '{8'h53, 8'h63, 8'h6F, 8'h72, 8'h65, 8'h3A, 8'h34, 8'h32,
                                8'h00, 8'h48, 8'h69, 8'h67, 8'h68, 8'h3A, 8'h30, 8'h30};
  logic       blink_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one pixel (plus the pending g_over/score/tick values), checks rom_addr now
  // and queues the expected output for the check two cycles later.
  task automatic step(input int x, input int y, input logic vo, input logic [7:0] code,
                      input logic on, input logic hi, input string tag);
    logic [9:0]  xv, yv;
    logic [3:0]  row;
    logic [2:0]  b;
    logic [10:0] a;
    logic [7:0]  f, rgb;
    string       t;
    @(negedge clk);
    if (exp_on_q.size() >= 2) begin
      t = exp_tag_q.pop_front();
      check({t, ".on"},  {31'd0, text_on},  {31'd0, exp_on_q.pop_front()});
      check({t, ".rgb"}, {24'd0, text_rgb}, {24'd0, exp_rgb_q.pop_front()});
    end
    xv = 10'(x);
    yv = 10'(y);
    pix_x = xv; pix_y = yv; video_on = vo;
    g_over = g_over_n; frame_tick = tick_n; score = score_n;
    tick_n = 1'b0;
    row = g_over_n ? yv[5:2] : yv[3:0];
    b   = g_over_n ? xv[4:2] : xv[2:0];
    a   = {code[6:0], row};
    f   = font(a);
    rgb = (on && f[3'd7 - b]) ? (hi ? HI : FG) : 8'h00;
    #1;
    check({tag, ".addr"}, {21'd0, rom_if.rom_addr}, {21'd0, a});
    exp_on_q.push_back(on);
    exp_rgb_q.push_back(rgb);
    exp_tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1023, 1023, 1'b0, 8'h00, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst.on",   {31'd0, text_on},  32'd0);
    check("rst.rgb",  {24'd0, text_rgb}, 32'd0);
    check("rst.high", {24'd0, high},     32'd0);
    reset = 1'b0;

    // Status line "Score:42 High:00", one pixel per cell with a varying bit position.
    for (int c = 0; c < 16; c++)
      step(c * 8 + c % 8, 5, 1'b1, st_codes[c], 1'b1, 1'b0, $sformatf("st%0d", c));
    step(128, 5, 1'b1, 8'h00, 1'b0, 1'b0, "st_end");
    step(48, 16, 1'b1, 8'h00, 1'b0, 1'b0, "st_row1");
    step(50, 5, 1'b0, 8'h34, 1'b0, 1'b0, "vo_off");
    step(50, 5, 1'b1, 8'h34, 1'b1, 1'b0, "vo_on");
    score_n = 8'h4A;
    step(56, 5, 1'b1, 8'h3A, 1'b1, 1'b0, "bcd_a");
    idle(2);

    // First game over sets high=17, then the status line shows it.
    score_n = 8'h17; g_over_n = 1'b1;
    idle(2);
    check("high17", {24'd0, high}, 32'h17);
    g_over_n = 1'b0;
    idle(1);
    step(113, 5, 1'b1, 8'h31, 1'b1, 1'b0, "st_hi1");
    step(122, 5, 1'b1, 8'h37, 1'b1, 1'b0, "st_hi0");

    // New high score 42: banner digits in HI colour, label in FG.
    score_n = 8'h42; g_over_n = 1'b1;
    idle(1);
    step(196, 200, 1'b1, 8'h53, 1'b1, 1'b0, "bn_s");
    check("high42", {24'd0, high}, 32'h42);
    step(388, 200, 1'b1, 8'h34, 1'b1, 1'b1, "bn_d1");
    step(428, 200, 1'b1, 8'h32, 1'b1, 1'b1, "bn_d0");
    step(356, 200, 1'b1, 8'h3A, 1'b1, 1'b0, "bn_colon");
    step(448, 200, 1'b1, 8'h00, 1'b0, 1'b0, "bn_right");
    step(160, 200, 1'b1, 8'h00, 1'b0, 1'b0, "bn_left");
    step(48, 5, 1'b1, 8'h00, 1'b0, 1'b0, "bn_status_off");
    step(388, 256, 1'b1, 8'h00, 1'b0, 1'b0, "bn_below");
    idle(2);

    // Equal score: no new high, digits in FG.
    g_over_n = 1'b0;
    idle(2);
    g_over_n = 1'b1;
    idle(1);
    step(388, 200, 1'b1, 8'h34, 1'b1, 1'b0, "eq_d1");
    check("high_eq", {24'd0, high}, 32'h42);
    step(196, 200, 1'b1, 8'h53, 1'b1, 1'b0, "eq_s");
    idle(2);

    // Blink with BLINK_FRAMES=2; the first tick coincides with the g_over rise.
    g_over_n = 1'b0;
    idle(1);
    g_over_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_n = 1'b1;
      idle(1);
      step(196, 200, 1'b1, 8'h53, blink_exp[i], 1'b0, $sformatf("blink%0d", i));
    end
    idle(2);

    // High 99, then a one-cycle reset mid-line with g_over still high.
    g_over_n = 1'b0;
    idle(1);
    score_n = 8'h99; g_over_n = 1'b1;
    idle(2);
    check("high99", {24'd0, high}, 32'h99);
    step(196, 200, 1'b1, 8'h53, 1'b1, 1'b0, "pre_rst_s");
    step(388, 200, 1'b1, 8'h39, 1'b1, 1'b1, "pre_rst_d");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst.on",   {31'd0, text_on},  32'd0);
    check("mid_rst.rgb",  {24'd0, text_rgb}, 32'd0);
    check("mid_rst.high", {24'd0, high},     32'd0);
    reset = 1'b0;
    exp_on_q.delete();
    exp_rgb_q.delete();
    exp_tag_q.delete();
    @(negedge clk);
    check("rst_flush.on", {31'd0, text_on}, 32'd0);
    check("rst_rise.high", {24'd0, high}, 32'h99);
    step(196, 200, 1'b1, 8'h53, 1'b1, 1'b0, "post_rst_s");
    step(388, 200, 1'b1, 8'h39, 1'b1, 1'b1, "post_rst_d");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
